reaction_timer_ctrl: RTL and testbench
======================================

REACTION_TIMER_CTRL -- requirements
Module: reaction_timer_ctrl

Interface
REQ-001 The parameter MIN_DELAY_MS SHALL have default 500 and SHALL set the fixed part of the random wait, in ms.
REQ-002 The parameter BEST_INIT SHALL have default 16'h9999 and SHALL set the reset value of the best-time BCD register.
REQ-003 MAX10_CLK1_50  input  1  SHALL be the 50 MHz system clock; all state is updated on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 ms_tick  input  1  SHALL be a one-cycle strobe, once per millisecond, from the clock divider.
REQ-006 start_n  input  1  SHALL be the raw start button (KEY[0]), active-low and asynchronous.
REQ-007 stop_n  input  1  SHALL be the raw react button (KEY[1]), active-low and asynchronous.
REQ-008 clr_best  input  1  SHALL be a synchronous high-score clear level (SW[0]).
REQ-009 rand_delay  input  11  SHALL be the LFSR value, sampled once per round.
REQ-010 leds  output  10  SHALL drive LEDR.
REQ-011 time_bcd  output  16  SHALL carry the last reaction time as four BCD digits, s.mmm, digit 3 = seconds.
REQ-012 best_bcd  output  16  SHALL carry the best time as four BCD digits.
REQ-013 disp_sel  output  2  SHALL select the display source: 0 blank, 1 time_bcd, 2 best_bcd, 3 "Err".
REQ-014 new_best  output  1  SHALL be high for the whole SHOW state when the current round set a new best.
REQ-015 state_o  output  3  SHALL expose the current state encoding for debug.

Function
REQ-016 start_n and stop_n SHALL each pass through a two-flop synchronizer; a press SHALL be the cycle in which the synchronized level goes 1->0.
REQ-017 The states SHALL be IDLE, ARM, WAIT, REACT, SHOW, BEST and FALSE.
REQ-018 IDLE SHALL move to ARM on a start press, with leds=0 and disp_sel=0 while in IDLE.
REQ-019 ARM SHALL stay while synchronized stop_n=0, and SHALL otherwise move to WAIT on the next cycle, latching delay = MIN_DELAY_MS + rand_delay as a 12-bit value, zero-extended.
REQ-020 WAIT SHALL decrement delay on each ms_tick and SHALL enter REACT on the tick where delay reaches 0.
REQ-021 On entering REACT, the BCD counter SHALL clear to 0000 and leds SHALL be 10'h3FF.
REQ-022 In REACT, the BCD counter SHALL increment on each ms_tick with decimal carry per digit.
REQ-023 In REACT, a stop press SHALL freeze time_bcd and move to SHOW on the next edge.
REQ-024 REACT SHALL saturate at 9999 and move to SHOW with time_bcd=9999 with no stop press.
REQ-025 On the entry edge into SHOW, if time_bcd < best_bcd (strict, unsigned compare of the packed BCD), best_bcd SHALL load time_bcd and new_best SHALL be set.
REQ-026 In SHOW, leds SHALL be 10'h2AA when new_best=1 and 0 otherwise, with disp_sel=1.
REQ-027 SHOW SHALL move to BEST on a stop press, and BEST (disp_sel=2) SHALL move to IDLE on a stop press.
REQ-028 A start press in SHOW or BEST SHALL go directly to ARM, and SHALL be ignored in ARM, WAIT and REACT.
REQ-029 A stop press and ms_tick in the same REACT cycle SHALL freeze the count including that tick.
REQ-030 clr_best=1 SHALL force best_bcd=BEST_INIT in every state, SHALL take priority over the SHOW update, and SHALL not change the state.

Reset
REQ-031 While rst_n=0, the block SHALL hold state=IDLE, leds=0, time_bcd=0, best_bcd=BEST_INIT, disp_sel=0, new_best=0, delay=0 and synchronizers=1.
REQ-032 Reset asserted mid-round SHALL abort the round and SHALL leave best_bcd at BEST_INIT.

Configuration
REQ-033 With FALSE_START_EN defined, a stop press in WAIT SHALL enter FALSE (leds=10'h155, disp_sel=3), FALSE SHALL return to IDLE on a start press, and best SHALL be untouched.
REQ-034 With FALSE_START_EN undefined, stop presses in WAIT SHALL be ignored and FALSE SHALL be unreachable.

Structure
REQ-035 The package reaction_pkg SHALL hold the state enum, the disp_sel codes, the LED patterns (ALL_ON, NEW_BEST, FALSE) and BCD_MAX=16'h9999.
REQ-036 The sub-module bcd_ms_counter (clr, en, sat flag, 16-bit BCD out) SHALL hold the 4-digit BCD counter.

Verification
REQ-037 Bench: MIN_DELAY_MS=5, rand=3, start press, then stop press after 250 ticks in REACT -> REACT entered on tick 8 of WAIT, time_bcd=0250, new_best=1, best=0250, leds=2AA.
REQ-038 Bench: second round with stop press after 300 ticks -> time_bcd=0300, best stays 0250, new_best=0, leds=0.
REQ-039 Bench: no stop press in REACT -> SHOW after 9999 ticks with time_bcd=9999 and best unchanged, because 9999 is not less than 9999.
REQ-040 Bench: stop held low through ARM -> state stays ARM until release, then WAIT.
REQ-041 Bench: FALSE_START_EN defined, stop press in WAIT -> FALSE, disp_sel=3, leds=155; the same stimulus undefined -> state stays WAIT.
REQ-042 Bench: clr_best pulse in SHOW and rst_n low in REACT -> best=9999 and state unchanged for the pulse; state=IDLE and all outputs at reset values for the reset.

Source files
------------

// File: rtl/reaction_pkg.sv
// rtl/reaction_pkg.sv - shared states, display codes and LED patterns for the reaction timer
package reaction_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_WAIT  = 3'd2,
        S_REACT = 3'd3,
        S_SHOW  = 3'd4,
        S_BEST  = 3'd5,
        S_FALSE = 3'd6
    } state_t;

    localparam logic [1:0] DISP_BLANK = 2'd0;
    localparam logic [1:0] DISP_TIME  = 2'd1;
    localparam logic [1:0] DISP_BEST  = 2'd2;
    localparam logic [1:0] DISP_ERR   = 2'd3;

    localparam logic [9:0] LED_ALL_ON   = 10'h3FF;
    localparam logic [9:0] LED_NEW_BEST = 10'h2AA;
    localparam logic [9:0] LED_FALSE    = 10'h155;

    localparam logic [15:0] BCD_MAX = 16'h9999;

endpackage

// File: rtl/bcd_ms_counter.sv
// rtl/bcd_ms_counter.sv - four-digit BCD millisecond counter with clear and saturation at 9999
module bcd_ms_counter
    import reaction_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    output logic [15:0] count,
    output logic [15:0] count_next,
    output logic        sat
);

    logic [15:0] inc;
    logic        carry;

    always_comb begin
        inc   = count;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (count[4*i +: 4] == 4'd9) begin
                    inc[4*i +: 4] = 4'd0;
                end else begin
                    inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
    end

    assign sat = (count == BCD_MAX);

    // The next value is exported so the owner can compare against it on the same edge it is stored.
    assign count_next = clr ? 16'h0000 : ((en && !sat) ? inc : count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 16'h0000;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/reaction_timer_ctrl.sv
// rtl/reaction_timer_ctrl.sv - reaction timer game controller; FALSE_START_EN enables false-start detection in WAIT
module reaction_timer_ctrl
    import reaction_pkg::*;
#(
    parameter int          MIN_DELAY_MS = 500,
    parameter logic [15:0] BEST_INIT    = 16'h9999
) (
    input  logic        MAX10_CLK1_50,
    input  logic        rst_n,
    input  logic        ms_tick,
    input  logic        start_n,
    input  logic        stop_n,
    input  logic        clr_best,
    input  logic [10:0] rand_delay,
    output logic [9:0]  leds,
    output logic [15:0] time_bcd,
    output logic [15:0] best_bcd,
    output logic [1:0]  disp_sel,
    output logic        new_best,
    output logic [2:0]  state_o
);

    localparam logic [11:0] MIN_DELAY = 12'(MIN_DELAY_MS);

    state_t      state;
    state_t      state_next;
    logic        start_s1, start_s2, start_d;
    logic        stop_s1, stop_s2, stop_d;
    logic        start_press, stop_press;
    logic [11:0] delay;
    logic        cnt_clr, cnt_en, cnt_sat;
    logic [15:0] cnt_next;
    logic        show_entry, better;

    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            {start_s1, start_s2, start_d} <= 3'b111;
            {stop_s1, stop_s2, stop_d}    <= 3'b111;
        end else begin
            {start_s1, start_s2, start_d} <= {start_n, start_s1, start_s2};
            {stop_s1, stop_s2, stop_d}    <= {stop_n, stop_s1, stop_s2};
        end
    end

    assign start_press = start_d & ~start_s2;
    assign stop_press  = stop_d & ~stop_s2;

    bcd_ms_counter u_counter (
        .clk        (MAX10_CLK1_50),
        .rst_n      (rst_n),
        .clr        (cnt_clr),
        .en         (cnt_en),
        .count      (time_bcd),
        .count_next (cnt_next),
        .sat        (cnt_sat)
    );

    always_comb begin
        state_next = state;
        leds       = 10'h000;
        disp_sel   = DISP_BLANK;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            S_IDLE: if (start_press) state_next = S_ARM;
            S_ARM:  if (stop_s2) state_next = S_WAIT;
            S_WAIT: begin
`ifdef FALSE_START_EN
                if (stop_press) begin
                    state_next = S_FALSE;
                end else
`endif
                if (ms_tick && delay <= 12'd1) begin
                    state_next = S_REACT;
                    cnt_clr    = 1'b1;
                end
            end
            S_REACT: begin
                leds     = LED_ALL_ON;
                disp_sel = DISP_TIME;
                cnt_en   = ms_tick;
                if (stop_press || cnt_sat) state_next = S_SHOW;
            end
            S_SHOW: begin
                leds     = new_best ? LED_NEW_BEST : 10'h000;
                disp_sel = DISP_TIME;
                if (start_press)     state_next = S_ARM;
                else if (stop_press) state_next = S_BEST;
            end
            S_BEST: begin
                disp_sel = DISP_BEST;
                if (start_press)     state_next = S_ARM;
                else if (stop_press) state_next = S_IDLE;
            end
            S_FALSE: begin
                leds     = LED_FALSE;
                disp_sel = DISP_ERR;
                if (start_press) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            delay <= 12'd0;
        end else if (state == S_ARM && stop_s2) begin
            delay <= MIN_DELAY + {1'b0, rand_delay};
        end else if (state == S_WAIT && ms_tick && delay != 12'd0) begin
            delay <= delay - 12'd1;
        end
    end

    // Compare against the post-edge count so a tick coinciding with the stop press is included.
    assign show_entry = (state == S_REACT) && (state_next == S_SHOW);
    assign better     = cnt_next < best_bcd;

    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            best_bcd <= BEST_INIT;
            new_best <= 1'b0;
        end else begin
            if (clr_best) begin
                best_bcd <= BEST_INIT;
            end else if (show_entry && better) begin
                best_bcd <= cnt_next;
            end
            if (show_entry) begin
                new_best <= better && !clr_best;
            end else if (state_next != S_SHOW) begin
                new_best <= 1'b0;
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// tb/tb_reaction_timer_ctrl.sv - table-driven, scoreboarded bench for reaction_timer_ctrl
module tb_reaction_timer_ctrl;
    import reaction_pkg::*;

    typedef struct {
        int          ticks;
        int          coin;
        logic [15:0] exp_time;
        logic [15:0] exp_best;
        logic        exp_nb;
        logic [9:0]  exp_leds;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ms_tick = 1'b0;
    logic        start_n = 1'b1;
    logic        stop_n = 1'b1;
    logic        clr_best = 1'b0;
    logic [10:0] rand_delay = 11'd3;
    logic [9:0]  leds;
    logic [15:0] time_bcd, best_bcd;
    logic [1:0]  disp_sel;
    logic        new_best;
    logic [2:0]  state_o;

    int   n_vec = 0;
    int   n_mis = 0;
    vec_t vecs[6];
    vec_t sb_q[$];
    vec_t v;

    reaction_timer_ctrl #(.MIN_DELAY_MS(5)) dut (
        .MAX10_CLK1_50 (clk),
        .rst_n         (rst_n),
        .ms_tick       (ms_tick),
        .start_n       (start_n),
        .stop_n        (stop_n),
        .clr_best      (clr_best),
        .rand_delay    (rand_delay),
        .leds          (leds),
        .time_bcd      (time_bcd),
        .best_bcd      (best_bcd),
        .disp_sel      (disp_sel),
        .new_best      (new_best),
        .state_o       (state_o)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int max, input string name);
        int hit = 0;
        for (int i = 0; i < max && hit == 0; i++) begin
            @(negedge clk);
            if (state_o == s) hit = 1;
        end
        check(name, state_o, s);
    endtask

    task automatic tick();
        @(negedge clk) ms_tick = 1'b1;
        @(negedge clk) ms_tick = 1'b0;
    endtask

    task automatic start_round();
        start_n = 1'b0;
        wait_state(S_WAIT, 12, "to_wait");
        start_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic reach_react();
        int got = 0;
        for (int k = 1; k <= 20 && got == 0; k++) begin
            tick();
            if (state_o == S_REACT) got = k;
        end
        check("react_on_tick", got, 8);
        check("react_leds", leds, LED_ALL_ON);
        check("react_time_clr", time_bcd, 16'h0000);
    endtask

    task automatic compare_show();
        vec_t e;
        if (sb_q.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb_q.pop_front();
            check("show_time", time_bcd, e.exp_time);
            check("show_best", best_bcd, e.exp_best);
            check("show_new_best", new_best, e.exp_nb);
            check("show_leds", leds, e.exp_leds);
            check("show_disp", disp_sel, DISP_TIME);
        end
    endtask

    task automatic finish_round(input vec_t r);
        repeat (r.ticks - r.coin) tick();
        sb_q.push_back(r);
        stop_n = 1'b0;
        if (r.coin != 0) begin
            @(negedge clk);
            @(negedge clk) ms_tick = 1'b1;
            @(negedge clk) ms_tick = 1'b0;
        end
        wait_state(S_SHOW, 10, "to_show");
        compare_show();
        stop_n = 1'b1;
        repeat (4) @(negedge clk);
        check("new_best_held", new_best, r.exp_nb);
    endtask

    task automatic go_idle();
        stop_n = 1'b0;
        wait_state(S_BEST, 10, "to_best");
        check("best_disp", disp_sel, DISP_BEST);
        stop_n = 1'b1;
        repeat (3) @(negedge clk);
        stop_n = 1'b0;
        wait_state(S_IDLE, 10, "to_idle");
        check("idle_disp", disp_sel, DISP_BLANK);
        check("idle_leds", leds, 10'h000);
        stop_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{250,  0, 16'h0250, 16'h0250, 1'b1, LED_NEW_BEST};
        vecs[1] = '{300,  0, 16'h0300, 16'h0250, 1'b0, 10'h000};
        vecs[2] = '{100,  0, 16'h0100, 16'h0100, 1'b1, LED_NEW_BEST};
        vecs[3] = '{100,  0, 16'h0100, 16'h0100, 1'b0, 10'h000};
        vecs[4] = '{6,    1, 16'h0006, 16'h0006, 1'b1, LED_NEW_BEST};
        vecs[5] = '{1000, 0, 16'h1000, 16'h0006, 1'b0, 10'h000};

        @(negedge clk);
        check("rst_state", state_o, S_IDLE);
        check("rst_leds", leds, 10'h000);
        check("rst_time", time_bcd, 16'h0000);
        check("rst_best", best_bcd, 16'h9999);
        check("rst_disp", disp_sel, DISP_BLANK);
        check("rst_nb", new_best, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            start_round();
            reach_react();
            finish_round(vecs[i]);
            if (i == 0) go_idle();
        end

        clr_best = 1'b1;
        @(negedge clk);
        clr_best = 1'b0;
        check("clr_best_val", best_bcd, 16'h9999);
        check("clr_state", state_o, S_SHOW);

        start_round();
        reach_react();
        repeat (9998) tick();
        check("sat_9998", time_bcd, 16'h9998);
        check("sat_state", state_o, S_REACT);
        sb_q.push_back('{9999, 0, 16'h9999, 16'h9999, 1'b0, 10'h000});
        tick();
        check("sat_9999", time_bcd, 16'h9999);
        @(negedge clk);
        check("sat_show", state_o, S_SHOW);
        compare_show();
        go_idle();

        stop_n = 1'b0;
        repeat (3) @(negedge clk);
        start_n = 1'b0;
        wait_state(S_ARM, 10, "hold_arm");
        repeat (10) @(negedge clk);
        check("arm_held", state_o, S_ARM);
        start_n = 1'b1;
        stop_n  = 1'b1;
        wait_state(S_WAIT, 10, "arm_release");
        repeat (2) @(negedge clk);

        stop_n = 1'b0;
        repeat (6) @(negedge clk);
`ifdef FALSE_START_EN
        check("false_state", state_o, S_FALSE);
        check("false_disp", disp_sel, DISP_ERR);
        check("false_leds", leds, LED_FALSE);
        check("false_best", best_bcd, 16'h9999);
        stop_n  = 1'b1;
        start_n = 1'b0;
        wait_state(S_IDLE, 10, "false_to_idle");
        start_n = 1'b1;
        repeat (3) @(negedge clk);
        start_round();
`else
        check("wait_ignores_stop", state_o, S_WAIT);
        stop_n = 1'b1;
        repeat (3) @(negedge clk);
`endif
        reach_react();
        finish_round('{40, 0, 16'h0040, 16'h0040, 1'b1, LED_NEW_BEST});

        start_round();
        reach_react();
        repeat (20) tick();
        check("pre_rst_time", time_bcd, 16'h0020);
        rst_n = 1'b0;
        #1;
        check("mid_rst_state", state_o, S_IDLE);
        check("mid_rst_best", best_bcd, 16'h9999);
        check("mid_rst_time", time_bcd, 16'h0000);
        check("mid_rst_leds", leds, 10'h000);
        check("mid_rst_disp", disp_sel, DISP_BLANK);
        check("mid_rst_nb", new_best, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
